// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller command port. Port A (capture)
// has priority, bounded by a streak limit; read data is routed back through a tag FIFO.
module sdram_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 32,
    parameter int MAX_A_STREAK = 4,
    parameter int TAG_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_rw,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_rw,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic [DATA_W-1:0] data_in,
    output logic              in_valid,
    input  logic              busy,
    input  logic [DATA_W-1:0] data_out,
    input  logic              out_valid,
    output logic              tag_err
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(TAG_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
    localparam logic [3:0]    MAX_C      = 4'(MAX_A_STREAK);
    localparam logic [3:0]    STREAK_ONE = 4'd1;
    localparam logic          OWN_A      = 1'b0;
    localparam logic          OWN_B      = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              load_s;
    logic              sel_valid_s;
    logic              sel_b_s;
    logic              a_elig_s;
    logic              b_elig_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              head_tag_s;

    logic              owner_r;
    logic              in_valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic              rw_r;
    logic [DATA_W-1:0] data_in_r;
    logic [3:0]        streak_r;
    logic              tag_mem_r [TAG_DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              a_rvalid_r;
    logic              b_rvalid_r;
    logic [DATA_W-1:0] a_rdata_r;
    logic [DATA_W-1:0] b_rdata_r;
    logic              tag_err_r;

    // Reads need a free tag slot; writes never wait on the FIFO.
    assign a_elig_s   = a_req && (a_rw || (count_r < DEPTH_C));
    assign b_elig_s   = b_req && (b_rw || (count_r < DEPTH_C));
    assign accept_s   = (state_r == ISSUE) && !busy;
    assign push_s     = accept_s && !rw_r;
    assign pop_s      = out_valid && (count_r != CNT_ZERO);
    assign head_tag_s = tag_mem_r[rd_ptr_r];

    assign a_ack    = accept_s && (owner_r == OWN_A);
    assign b_ack    = accept_s && (owner_r == OWN_B);
    assign in_valid = in_valid_r;
    assign addr     = addr_r;
    assign rw       = rw_r;
    assign data_in  = data_in_r;
    assign a_rvalid = a_rvalid_r;
    assign b_rvalid = b_rvalid_r;
    assign a_rdata  = a_rdata_r;
    assign b_rdata  = b_rdata_r;
    assign tag_err  = tag_err_r;

    // Port selection: A wins unless B is eligible and A has used up its streak.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_b_s     = 1'b0;
        if (b_elig_s && (streak_r == MAX_C)) begin
            sel_valid_s = 1'b1;
            sel_b_s     = 1'b1;
        end else if (a_elig_s) begin
            sel_valid_s = 1'b1;
            sel_b_s     = 1'b0;
        end else if (b_elig_s) begin
            sel_valid_s = 1'b1;
            sel_b_s     = 1'b1;
        end else begin
            sel_valid_s = 1'b0;
            sel_b_s     = 1'b0;
        end
    end

    // Next-state logic for the command FSM.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_valid_s) begin
                    state_nxt_s = ISSUE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (!busy) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and the command held towards the controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            in_valid_r <= 1'b0;
            owner_r    <= OWN_A;
            addr_r     <= {ADDR_W{1'b0}};
            rw_r       <= 1'b0;
            data_in_r  <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            in_valid_r <= (state_nxt_s == ISSUE);
            if (load_s) begin
                owner_r   <= sel_b_s;
                addr_r    <= sel_b_s ? b_addr  : a_addr;
                rw_r      <= sel_b_s ? b_rw    : a_rw;
                data_in_r <= sel_b_s ? b_wdata : a_wdata;
            end
        end
    end

    // Consecutive A grants while B waits; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_r <= 4'd0;
        end else if (accept_s) begin
            if (owner_r == OWN_B || !b_req) begin
                streak_r <= 4'd0;
            end else if (streak_r < MAX_C) begin
                streak_r <= streak_r + STREAK_ONE;
            end
        end
    end

    // Tag FIFO remembering which port owns each outstanding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= 1'b0;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= owner_r;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Read return routing; data is held per port until its next rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            a_rdata_r  <= {DATA_W{1'b0}};
            b_rdata_r  <= {DATA_W{1'b0}};
            tag_err_r  <= 1'b0;
        end else begin
            a_rvalid_r <= pop_s && (head_tag_s == OWN_A);
            b_rvalid_r <= pop_s && (head_tag_s == OWN_B);
            if (pop_s && (head_tag_s == OWN_A)) begin
                a_rdata_r <= data_out;
            end
            if (pop_s && (head_tag_s == OWN_B)) begin
                b_rdata_r <= data_out;
            end
            if (out_valid && (count_r == CNT_ZERO)) begin
                tag_err_r <= 1'b1;
            end
        end
    end

endmodule
